// File: rtl/cache_ctrl.sv
`timescale 1ns/1ps
// cache_ctrl: sequencer for a 4-way set-associative, write-through / no-write-allocate data cache.
// Load hits complete in zero wait states; misses refill over a req/gnt/rvalid bus; victims by tree PLRU.
module cache_ctrl #(
  parameter int SET_BITS   = 4,
  parameter int TAG_BITS   = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  cache_hit_i,
  input  logic [1:0]            cache_hit_way_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  input  logic [3:0]            cache_valid_i,
  output logic                  cache_wr_o,
  output logic                  cache_alloc_o,
  output logic [1:0]            cache_way_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int SETS = 2 ** SET_BITS;
  localparam int AW   = TAG_BITS + SET_BITS + 2;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   fill_q;
  logic [1:0]              victim_q;
  logic [2:0]              plru_q [SETS];

  logic [SET_BITS-1:0]     cpu_set, fill_set, touch_set;
  logic [1:0]              victim, touch_way;
  logic                    touch_en;
  logic                    idle_req, load_hit, store_hit;

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (b[0]) return b[2] ? 2'd3 : 2'd2;
    return b[1] ? 2'd1 : 2'd0;
  endfunction

  // Bit 0 steers between halves, bits 1/2 within each half; every touch points them away from w.
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r    = b;
    r[0] = ~w[1];
    if (!w[1]) r[1] = (w == 2'd0);
    else       r[2] = (w == 2'd2);
    return r;
  endfunction

  assign cpu_set   = cpu_addr_i[SET_BITS+1:2];
  assign fill_set  = addr_q[SET_BITS+1:2];
  assign idle_req  = (state_q == IDLE) && cpu_req_i;
  assign load_hit  = idle_req && !cpu_we_i && cache_hit_i;
  assign store_hit = idle_req && cpu_we_i && cache_hit_i;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    victim = plru_victim(plru_q[cpu_set]);
    for (int w = 3; w >= 0; w--) begin
      if (!cache_valid_i[w]) victim = 2'(w);
    end
  end

  always_comb begin
    touch_en  = load_hit || store_hit || (state_q == FILL);
    touch_set = (state_q == FILL) ? fill_set : cpu_set;
    touch_way = (state_q == FILL) ? victim_q : cache_hit_way_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (cpu_we_i)         state_d = WR_REQ;
          else if (!cache_hit_i) state_d = RD_REQ;
        end
      end
      RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_d = FILL;
      FILL:                      state_d = IDLE;
      WR_REQ:  if (mem_gnt_i)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_o   = 1'b0;
    cpu_rdata_o   = '0;
    cache_wr_o    = 1'b0;
    cache_alloc_o = 1'b0;
    cache_way_o   = 2'd0;
    cache_wdata_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state_q)
      IDLE: begin
        if (load_hit) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = cache_rdata_i;
        end
        if (store_hit) begin
          cache_wr_o    = 1'b1;
          cache_way_o   = cache_hit_way_i;
          cache_wdata_o = cpu_wdata_i;
        end
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
      end
      FILL: begin
        cache_wr_o    = 1'b1;
        cache_alloc_o = 1'b1;
        cache_way_o   = victim_q;
        cache_wdata_o = fill_q;
        cpu_ready_o   = 1'b1;
        cpu_rdata_o   = fill_q;
      end
      WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        cpu_ready_o = mem_gnt_i;
      end
      default: ;
    endcase
  end

  // Request context is captured on acceptance so the bus sees stable values while waiting for gnt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= 2'd0;
      fill_q   <= '0;
    end else begin
      if (idle_req) begin
        addr_q   <= cpu_addr_i & ~32'd3;
        wdata_q  <= cpu_wdata_i;
        victim_q <= victim;
      end
      if (state_q == RD_WAIT && mem_rvalid_i) fill_q <= mem_rdata_i;
    end
  end

  // NOTE: the PLRU store is a small flop array, not RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
    end else if (touch_en) begin
      plru_q[touch_set] <= plru_touch(plru_q[touch_set], touch_way);
    end
  end

endmodule
